vend_controller: RTL and testbench

- Sequencing controller for the vending datapath.
- Accepts nickel/dime/quarter pulses and accumulates the deposit toward a fixed item price.
- Hands a vend request to the dispenser, then hands any change or refund to the change dispenser, each over a valid/ready handshake.
- Also blocks coins while busy, refunds on cancel or inactivity timeout, and counts completed sales.

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_timer.sv | 38 +++
 rtl/vend_controller.sv | 196 +++++++++++++++++++
 tb/tb_vend_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
//   state_t       : controller state encoding
//   *_VAL         : coin values in cents
//   PRICE_DEFAULT : default item price in cents
//   coin_value()  : priority coin decode (nickel > dime > quarter)
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    VEND,
    CHANGE,
    REFUND
  } state_t;

  localparam int unsigned NICKLE_VAL    = 5;
  localparam int unsigned DIME_VAL      = 10;
  localparam int unsigned QUARTER_VAL   = 25;
  localparam int unsigned PRICE_DEFAULT = 20;

  function automatic int unsigned coin_value(input logic nickle,
                                             input logic dime,
                                             input logic quarter);
    if (nickle)       return NICKLE_VAL;
    else if (dime)    return DIME_VAL;
    else if (quarter) return QUARTER_VAL;
    else              return 0;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Inactivity timer for the coin collection phase.
// Down-counter loaded with TIMEOUT-1 on clear; expire is a single-cycle
// pulse on the TIMEOUT-th enabled cycle after the last clear.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear   : reload the counter (accepted coin, or not collecting)
//   enable  : count this cycle
//   expire  : terminal count reached while enabled
module vend_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

  logic [TW-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= LOAD;
    end else if (enable && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

  // The controller leaves COLLECT on expire, which drops enable, so the
  // pulse cannot repeat.
  assign expire = enable && !clear && (remaining == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending sequencing controller.
// Accumulates coin pulses toward PRICE, issues a vend request, then returns
// change or a refund over valid/ready handshakes, and counts sales.
//   clk_i, rst_ni          : clock (rising edge), async active-low reset
//   nickle_i/dime_i/quarter_i : one-cycle coin pulses
//   cancel_i               : customer cancel (honoured only in COLLECT)
//   coin_ready_o           : coins accepted this cycle (combinational)
//   coin_reject_o          : registered pulse, a coin was returned
//   deposit_o              : accumulated deposit in cents
//   vend_valid_o/vend_ready_i     : dispense request handshake
//   change_valid_o/change_ready_i : change/refund handshake
//   change_amt_o, refund_o : change payload; refund_o=1 means no item vended
//   sales_o                : completed vends, wrapping counter
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no deposit, waiting for the first coin
// COLLECT | deposit below price, accepting coins, inactivity timer runs
// VEND    | price reached, vend request held until dispenser accepts
// CHANGE  | item vended, returning deposit-PRICE
// REFUND  | cancelled or timed out, returning the whole deposit
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE   = PRICE_DEFAULT,
  parameter int unsigned DW      = 6,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          nickle_i,
  input  logic          dime_i,
  input  logic          quarter_i,
  input  logic          cancel_i,
  output logic          coin_ready_o,
  output logic          coin_reject_o,
  output logic [DW-1:0] deposit_o,
  output logic          vend_valid_o,
  input  logic          vend_ready_i,
  output logic          change_valid_o,
  output logic [DW-1:0] change_amt_o,
  output logic          refund_o,
  input  logic          change_ready_i,
  output logic [CW-1:0] sales_o
);

  localparam logic [DW-1:0] PRICE_W = DW'(PRICE);

  state_t        state, state_nxt;
  logic [DW-1:0] deposit, deposit_nxt;
  logic [DW-1:0] change_amt, change_amt_nxt;
  logic          refund, refund_nxt;
  logic          vend_valid, vend_valid_nxt;
  logic          change_valid, change_valid_nxt;
  logic          reject, reject_nxt;
  logic [CW-1:0] sales, sales_nxt;

  logic          coin_ready;
  logic          coin_any;
  logic          coin_multi;
  logic          accept;
  logic [DW-1:0] coin_val;
  logic [DW-1:0] sum;
  logic          timer_clr;
  logic          timer_en;
  logic          timer_expire;

  // Coin decode: only the highest-priority pulse is taken; the rest, or any
  // coin while busy, are returned via coin_reject_o on the next cycle.
  assign coin_ready = (state == IDLE) || (state == COLLECT);
  assign coin_any   = nickle_i | dime_i | quarter_i;
  assign coin_multi = (nickle_i & dime_i) | (nickle_i & quarter_i) | (dime_i & quarter_i);
  assign accept     = coin_ready && coin_any;
  assign coin_val   = DW'(coin_value(nickle_i, dime_i, quarter_i));
  assign sum        = deposit + coin_val;

  assign timer_en  = (state == COLLECT) && !accept;
  assign timer_clr = accept || (state != COLLECT);

  vend_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clear  (timer_clr),
    .enable (timer_en),
    .expire (timer_expire)
  );

  // State register; every output except coin_ready_o is registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      deposit      <= '0;
      change_amt   <= '0;
      refund       <= 1'b0;
      vend_valid   <= 1'b0;
      change_valid <= 1'b0;
      reject       <= 1'b0;
      sales        <= '0;
    end else begin
      state        <= state_nxt;
      deposit      <= deposit_nxt;
      change_amt   <= change_amt_nxt;
      refund       <= refund_nxt;
      vend_valid   <= vend_valid_nxt;
      change_valid <= change_valid_nxt;
      reject       <= reject_nxt;
      sales        <= sales_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (coin_val >= PRICE_W) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        // A coin arriving with cancel is added before cancel is considered.
        if (accept) begin
          if (sum >= PRICE_W)  state_nxt = VEND;
          else if (cancel_i)   state_nxt = REFUND;
        end else if (cancel_i || timer_expire) begin
          state_nxt = REFUND;
        end
      end
      VEND: begin
        if (vend_ready_i) begin
          state_nxt = (deposit == PRICE_W) ? IDLE : CHANGE;
        end
      end
      CHANGE, REFUND: begin
        if (change_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values, registered alongside the state.
  always_comb begin
    deposit_nxt    = deposit;
    change_amt_nxt = change_amt;
    refund_nxt     = refund;
    sales_nxt      = sales;
    reject_nxt     = coin_ready ? coin_multi : coin_any;
    case (state)
      IDLE, COLLECT: begin
        if (accept) deposit_nxt = sum;
        if (state_nxt == REFUND) begin
          change_amt_nxt = deposit_nxt;
          refund_nxt     = 1'b1;
        end
      end
      VEND: begin
        if (vend_ready_i) begin
          sales_nxt = sales + CW'(1);
          if (state_nxt == IDLE) begin
            deposit_nxt = '0;
          end else begin
            change_amt_nxt = deposit - PRICE_W;
            refund_nxt     = 1'b0;
          end
        end
      end
      CHANGE, REFUND: begin
        if (change_ready_i) begin
          deposit_nxt    = '0;
          change_amt_nxt = '0;
          refund_nxt     = 1'b0;
        end
      end
      default: begin
        deposit_nxt    = '0;
        change_amt_nxt = '0;
        refund_nxt     = 1'b0;
      end
    endcase
    vend_valid_nxt   = (state_nxt == VEND);
    change_valid_nxt = (state_nxt == CHANGE) || (state_nxt == REFUND);
  end

  assign coin_ready_o   = coin_ready;
  assign coin_reject_o  = reject;
  assign deposit_o      = deposit;
  assign vend_valid_o   = vend_valid;
  assign change_valid_o = change_valid;
  assign change_amt_o   = change_amt;
  assign refund_o       = refund;
  assign sales_o        = sales;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller with a cycle-level behavioural model.
module tb_vend_controller;

  localparam int unsigned PRICE   = 20;
  localparam int unsigned DW      = 6;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CW      = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          nickle = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
  logic          vend_ready = 1'b0, change_ready = 1'b0;
  logic          coin_ready, coin_reject, vend_valid, change_valid, refund;
  logic [DW-1:0] deposit, change_amt;
  logic [CW-1:0] sales;

  int errors = 0;
  int checks = 0;

  vend_controller #(
    .PRICE(PRICE), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .nickle_i       (nickle),
    .dime_i         (dime),
    .quarter_i      (quarter),
    .cancel_i       (cancel),
    .coin_ready_o   (coin_ready),
    .coin_reject_o  (coin_reject),
    .deposit_o      (deposit),
    .vend_valid_o   (vend_valid),
    .vend_ready_i   (vend_ready),
    .change_valid_o (change_valid),
    .change_amt_o   (change_amt),
    .refund_o       (refund),
    .change_ready_i (change_ready),
    .sales_o        (sales)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a deposit amount plus two pending-transfer flags.
  int m_deposit = 0, m_change_amt = 0, m_sales = 0, m_idle = 0;
  bit m_vend = 0, m_change = 0, m_refund = 0, m_reject = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_deposit = 0; m_change_amt = 0; m_sales = 0; m_idle = 0;
      m_vend = 0; m_change = 0; m_refund = 0; m_reject = 0;
    end else begin
      int  ncoins, val;
      bit  accepting, collecting, go_refund;
      ncoins    = int'(nickle) + int'(dime) + int'(quarter);
      val       = nickle ? 5 : dime ? 10 : quarter ? 25 : 0;
      accepting = !(m_vend || m_change);
      collecting = accepting && (m_deposit != 0);
      go_refund = 0;
      m_reject  = accepting ? (ncoins > 1) : (ncoins > 0);
      if (m_vend) begin
        if (vend_ready) begin
          m_sales = (m_sales + 1) % (1 << CW);
          m_vend  = 0;
          if (m_deposit == PRICE) m_deposit = 0;
          else begin
            m_change = 1; m_change_amt = m_deposit - PRICE; m_refund = 0;
          end
        end
      end else if (m_change) begin
        if (change_ready) begin
          m_change = 0; m_deposit = 0; m_change_amt = 0; m_refund = 0;
        end
      end else if (ncoins > 0) begin
        m_deposit += val;
        m_idle = 0;
        if (m_deposit >= PRICE) m_vend = 1;
        else if (collecting && cancel) go_refund = 1;
      end else if (collecting) begin
        if (cancel || m_idle == TIMEOUT - 1) go_refund = 1;
        else m_idle++;
      end
      if (go_refund) begin
        m_change = 1; m_change_amt = m_deposit; m_refund = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_coin_ready",   coin_ready,   !(m_vend || m_change));
      check("m_coin_reject",  coin_reject,  m_reject);
      check("m_deposit",      deposit,      m_deposit);
      check("m_vend_valid",   vend_valid,   m_vend);
      check("m_change_valid", change_valid, m_change);
      check("m_change_amt",   change_amt,   m_change_amt);
      check("m_refund",       refund,       m_refund);
      check("m_sales",        sales,        m_sales);
    end
  end

  task automatic drive_coin(input logic n, input logic d, input logic q);
    nickle = n; dime = d; quarter = q;
    @(negedge clk);
    nickle = 0; dime = 0; quarter = 0;
  endtask

  int vv_cycles;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_deposit", deposit, 0);
    check("rst_coin_ready", coin_ready, 1);
    check("rst_sales", sales, 0);
    check("rst_vend_valid", vend_valid, 0);
    check("rst_change_valid", change_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // dime, dime with dispenser already ready: exact price, no change
    vend_ready = 1;
    drive_coin(0, 1, 0);
    check("s1_dep10", deposit, 10);
    drive_coin(0, 1, 0);
    check("s1_dep20", deposit, 20);
    check("s1_vend_valid", vend_valid, 1);
    check("s1_coin_ready", coin_ready, 0);
    @(negedge clk);
    check("s1_vend_done", vend_valid, 0);
    check("s1_sales", sales, 1);
    check("s1_change_valid", change_valid, 0);
    check("s1_idle_dep", deposit, 0);
    vend_ready = 0;

    // quarter, dispenser delayed three cycles; nickel and cancel ignored
    drive_coin(0, 0, 1);
    vv_cycles = vend_valid ? 1 : 0;
    check("s2_dep25", deposit, 25);
    for (int i = 0; i < 3; i++) begin
      nickle = (i == 0);
      cancel = (i == 1);
      @(negedge clk);
      nickle = 0; cancel = 0;
      if (vend_valid) vv_cycles++;
      check("s2_coin_ready_busy", coin_ready, 0);
      if (i == 0) check("s2_reject", coin_reject, 1);
      check("s2_dep_hold", deposit, 25);
    end
    vend_ready = 1;
    @(negedge clk);
    vend_ready = 0;
    check("s2_vv_cycles", vv_cycles, 4);
    check("s2_change_valid", change_valid, 1);
    check("s2_change_amt", change_amt, 5);
    check("s2_refund", refund, 0);
    check("s2_sales", sales, 2);
    repeat (2) begin
      @(negedge clk);
      check("s2_change_hold", change_amt, 5);
    end
    change_ready = 1;
    @(negedge clk);
    change_ready = 0;
    check("s2_change_done", change_valid, 0);
    check("s2_amt_clr", change_amt, 0);

    // all three coins at once: nickel taken, rest rejected
    drive_coin(1, 1, 1);
    check("s3_dep5", deposit, 5);
    check("s3_reject", coin_reject, 1);
    @(negedge clk);
    check("s3_reject_pulse", coin_reject, 0);

    // add a dime then cancel: refund 15
    drive_coin(0, 1, 0);
    check("s4_dep15", deposit, 15);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("s4_refund_valid", change_valid, 1);
    check("s4_refund_amt", change_amt, 15);
    check("s4_refund_flag", refund, 1);
    check("s4_sales", sales, 2);
    change_ready = 1;
    @(negedge clk);
    change_ready = 0;
    check("s4_idle", coin_ready, 1);
    check("s4_dep_clr", deposit, 0);

    // cancel in IDLE is ignored
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    check("s5_idle_cancel", change_valid, 0);

    // coin and cancel together below price: refund the new sum
    drive_coin(1, 0, 0);
    dime = 1; cancel = 1;
    @(negedge clk);
    dime = 0; cancel = 0;
    check("s6_refund_amt", change_amt, 15);
    check("s6_refund_flag", refund, 1);
    change_ready = 1;
    @(negedge clk);
    change_ready = 0;

    // coin and cancel together reaching price: vend wins, change 10
    drive_coin(1, 0, 0);
    quarter = 1; cancel = 1;
    @(negedge clk);
    quarter = 0; cancel = 0;
    check("s7_vend", vend_valid, 1);
    check("s7_dep30", deposit, 30);
    vend_ready = 1;
    @(negedge clk);
    vend_ready = 0;
    check("s7_change_amt", change_amt, 10);
    check("s7_sales", sales, 3);
    change_ready = 1;
    @(negedge clk);
    change_ready = 0;

    // inactivity timeout: refund exactly TIMEOUT cycles after the coin edge
    drive_coin(1, 0, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("s8_before_timeout", change_valid, 0);
    @(negedge clk);
    check("s8_timeout_valid", change_valid, 1);
    check("s8_timeout_amt", change_amt, 5);
    check("s8_timeout_refund", refund, 1);
    change_ready = 1;
    @(negedge clk);
    change_ready = 0;

    // 40 cents, then async reset in the middle of VEND
    drive_coin(1, 0, 0);
    drive_coin(0, 1, 0);
    drive_coin(0, 0, 1);
    check("s9_dep40", deposit, 40);
    check("s9_vend", vend_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s9_rst_dep", deposit, 0);
    check("s9_rst_vend", vend_valid, 0);
    check("s9_rst_change", change_valid, 0);
    check("s9_rst_sales", sales, 0);
    check("s9_rst_coin_ready", coin_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s9_after_rst_ready", coin_ready, 1);
    check("s9_after_rst_dep", deposit, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
